// File: rtl/tl_cache_skid_latch.sv
// TL -> cache-stage pipeline latch: 2-entry skid buffer with registered ready, kill flush.
// Optional saturating stall/bubble counters are enabled by defining TL_LATCH_STATS_EN.
module tl_cache_skid_latch #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int XLEN   = 32,
  parameter int WAYS   = 4,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
`ifdef TL_LATCH_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              kill_i,
  input  logic              tl_valid_i,
  output logic              tl_ready_o,
  input  logic [ADDR_W-1:0] tl_addr_i,
  input  logic              tl_rqst_byte_i,
  input  logic              tl_miss_i,
  input  logic              tl_buffer_hit_i,
  input  logic              tl_int_write_enable_i,
  input  logic [WAY_W-1:0]  tl_hit_way_i,
  input  logic [WAY_W-1:0]  tl_lru_way_i,
  input  logic [DATA_W-1:0] tl_buffer_data_i,
  input  logic [XLEN-1:0]   tl_write_addr_i,
  input  logic [XLEN-1:0]   tl_pc_i,
  output logic              c_valid_o,
  input  logic              c_ready_i,
  output logic [ADDR_W-1:0] c_addr_o,
  output logic              c_rqst_byte_o,
  output logic              c_miss_o,
  output logic              c_buffer_hit_o,
  output logic              c_int_write_enable_o,
  output logic [WAY_W-1:0]  c_hit_way_o,
  output logic [WAY_W-1:0]  c_lru_way_o,
  output logic [DATA_W-1:0] c_buffer_data_o,
  output logic [XLEN-1:0]   c_write_addr_o,
  output logic [XLEN-1:0]   c_pc_o,
  output logic [1:0]        occ_o
`ifdef TL_LATCH_STATS_EN
  , output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

  // Handshake: a beat moves when valid && ready are both high at a rising clk_i;
  // valid never waits on ready, and tl_ready_o is a pure register (no path from c_ready_i).
  localparam int PW = ADDR_W + 4 + 2 * WAY_W + DATA_W + 2 * XLEN;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q;
  logic            ready_q;
  logic [PW-1:0]   main_q;
  logic [PW-1:0]   skid_q;
  logic [PW-1:0]   in_pl;
  logic            in_xfer;
  logic            out_xfer;

  assign in_pl = {tl_addr_i, tl_rqst_byte_i, tl_miss_i, tl_buffer_hit_i,
                  tl_int_write_enable_i, tl_hit_way_i, tl_lru_way_i,
                  tl_buffer_data_i, tl_write_addr_i, tl_pc_i};

  assign {c_addr_o, c_rqst_byte_o, c_miss_o, c_buffer_hit_o,
          c_int_write_enable_o, c_hit_way_o, c_lru_way_o,
          c_buffer_data_o, c_write_addr_o, c_pc_o} = main_q;

  assign tl_ready_o = ready_q;
  assign c_valid_o  = (state_q != EMPTY);
  assign occ_o      = state_q;
  assign in_xfer    = tl_valid_i && ready_q;
  assign out_xfer   = c_valid_o && c_ready_i;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (kill_i) begin
      // Kill wins over everything, including a beat accepted in this same cycle.
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q  <= in_pl;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_pl;
          end else if (in_xfer) begin
            skid_q  <= in_pl;
            state_q <= FULL;
            ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef TL_LATCH_STATS_EN
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (c_valid_o && !c_ready_i && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (!c_valid_o && (bubble_cnt_o != {CNT_W{1'b1}}))
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_cache_skid_latch.sv
// Randomized + directed bench for tl_cache_skid_latch against a queue-based FIFO model.
module tb_tl_cache_skid_latch;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int XLEN   = 32;
  localparam int WAY_W  = 2;
  localparam int PW     = ADDR_W + 4 + 2 * WAY_W + DATA_W + 2 * XLEN;
`ifdef TL_LATCH_STATS_EN
  localparam int CNT_W  = 2;
`endif

  // clock / reset
  logic clk_i = 1'b0;
  logic rsn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              kill_i, tl_valid_i, tl_ready_o, c_valid_o, c_ready_i;
  logic [ADDR_W-1:0] tl_addr_i, c_addr_o;
  logic              tl_rqst_byte_i, tl_miss_i, tl_buffer_hit_i, tl_int_write_enable_i;
  logic              c_rqst_byte_o, c_miss_o, c_buffer_hit_o, c_int_write_enable_o;
  logic [WAY_W-1:0]  tl_hit_way_i, tl_lru_way_i, c_hit_way_o, c_lru_way_o;
  logic [DATA_W-1:0] tl_buffer_data_i, c_buffer_data_o;
  logic [XLEN-1:0]   tl_write_addr_i, tl_pc_i, c_write_addr_o, c_pc_o;
  logic [1:0]        occ_o;
`ifdef TL_LATCH_STATS_EN
  logic [CNT_W-1:0]  stall_cnt_o, bubble_cnt_o;
`endif

  tl_cache_skid_latch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .XLEN(XLEN), .WAYS(4)
`ifdef TL_LATCH_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .kill_i(kill_i),
    .tl_valid_i(tl_valid_i), .tl_ready_o(tl_ready_o),
    .tl_addr_i(tl_addr_i), .tl_rqst_byte_i(tl_rqst_byte_i), .tl_miss_i(tl_miss_i),
    .tl_buffer_hit_i(tl_buffer_hit_i), .tl_int_write_enable_i(tl_int_write_enable_i),
    .tl_hit_way_i(tl_hit_way_i), .tl_lru_way_i(tl_lru_way_i),
    .tl_buffer_data_i(tl_buffer_data_i), .tl_write_addr_i(tl_write_addr_i), .tl_pc_i(tl_pc_i),
    .c_valid_o(c_valid_o), .c_ready_i(c_ready_i),
    .c_addr_o(c_addr_o), .c_rqst_byte_o(c_rqst_byte_o), .c_miss_o(c_miss_o),
    .c_buffer_hit_o(c_buffer_hit_o), .c_int_write_enable_o(c_int_write_enable_o),
    .c_hit_way_o(c_hit_way_o), .c_lru_way_o(c_lru_way_o),
    .c_buffer_data_o(c_buffer_data_o), .c_write_addr_o(c_write_addr_o), .c_pc_o(c_pc_o),
    .occ_o(occ_o)
`ifdef TL_LATCH_STATS_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  // scoreboard: entries held by the latch, oldest first, plus what c_* must show when empty
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] shown_when_empty;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [PW-1:0] in_payload();
    return {tl_addr_i, tl_rqst_byte_i, tl_miss_i, tl_buffer_hit_i, tl_int_write_enable_i,
            tl_hit_way_i, tl_lru_way_i, tl_buffer_data_i, tl_write_addr_i, tl_pc_i};
  endfunction

  function automatic logic [PW-1:0] out_payload();
    return {c_addr_o, c_rqst_byte_o, c_miss_o, c_buffer_hit_o, c_int_write_enable_o,
            c_hit_way_o, c_lru_way_o, c_buffer_data_o, c_write_addr_o, c_pc_o};
  endfunction

  function automatic logic [PW-1:0] exp_shown();
    return (exp_q.size() > 0) ? exp_q[0] : shown_when_empty;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".occ"},   128'(occ_o),         128'(exp_q.size()));
    check({tag, ".valid"}, 128'(c_valid_o),     128'(exp_q.size() > 0));
    check({tag, ".ready"}, 128'(tl_ready_o),    128'(exp_q.size() < 2));
    check({tag, ".pl"},    128'(out_payload()), 128'(exp_shown()));
  endtask

  // driver: apply one cycle of inputs, advance the model across the edge, then check
  task automatic drive_cycle(input string tag, input bit v, input logic [XLEN-1:0] pc,
                             input logic [ADDR_W-1:0] addr, input bit rdy, input bit k);
    logic [PW-1:0] pl;
    bit in_x, out_x;
    tl_valid_i            = v;
    tl_pc_i               = pc;
    tl_addr_i             = addr;
    tl_rqst_byte_i        = 1'($urandom);
    tl_miss_i             = 1'($urandom);
    tl_buffer_hit_i       = 1'($urandom);
    tl_int_write_enable_i = 1'($urandom);
    tl_hit_way_i          = WAY_W'($urandom);
    tl_lru_way_i          = WAY_W'($urandom);
    tl_buffer_data_i      = $urandom;
    tl_write_addr_i       = $urandom;
    c_ready_i             = rdy;
    kill_i                = k;
    pl    = in_payload();
    in_x  = v && (exp_q.size() < 2);
    out_x = rdy && (exp_q.size() > 0);
    @(posedge clk_i);
    #1;
    if (k) begin
      exp_q.delete();
      shown_when_empty = '0;
    end else begin
      if (out_x) begin
        shown_when_empty = exp_q[0];
        void'(exp_q.pop_front());
      end
      if (in_x) exp_q.push_back(pl);
      if (exp_q.size() > 0) shown_when_empty = exp_q[0];
    end
    check_model(tag);
  endtask

  task automatic idle_inputs();
    kill_i = 0; tl_valid_i = 0; c_ready_i = 0;
    tl_addr_i = '0; tl_rqst_byte_i = 0; tl_miss_i = 0; tl_buffer_hit_i = 0;
    tl_int_write_enable_i = 0; tl_hit_way_i = '0; tl_lru_way_i = '0;
    tl_buffer_data_i = '0; tl_write_addr_i = '0; tl_pc_i = '0;
  endtask

  initial begin
    idle_inputs();
    exp_q.delete();
    shown_when_empty = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset.valid", 128'(c_valid_o), 128'(0));
    check("reset.ready", 128'(tl_ready_o), 128'(1));
    check("reset.occ",   128'(occ_o), 128'(0));
    check("reset.pl",    128'(out_payload()), 128'(0));
    rsn_i = 1'b1;

    // streaming
    for (int i = 0; i < 4; i++) begin
      drive_cycle("stream", 1, 32'h100 + 32'(4 * i), ADDR_W'($urandom), 1, 0);
      check("stream.pc", 128'(c_pc_o), 128'(32'h100 + 32'(4 * i)));
    end
    drive_cycle("drain", 0, '0, '0, 1, 0);

    // skid fill and drain
    drive_cycle("fill1", 1, 32'h200, ADDR_W'($urandom), 0, 0);
    drive_cycle("fill2", 1, 32'h204, ADDR_W'($urandom), 0, 0);
    check("skid.occ",   128'(occ_o), 128'(2));
    check("skid.ready", 128'(tl_ready_o), 128'(0));
    check("skid.pc",    128'(c_pc_o), 128'(32'h200));
    drive_cycle("skid.out1", 0, '0, '0, 1, 0);
    check("skid.pc2", 128'(c_pc_o), 128'(32'h204));
    drive_cycle("skid.out2", 0, '0, '0, 1, 0);
    check("skid.empty", 128'(c_valid_o), 128'(0));

    // kill priority over drain from FULL
    drive_cycle("kfill1", 1, 32'h200, ADDR_W'($urandom), 0, 0);
    drive_cycle("kfill2", 1, 32'h204, ADDR_W'($urandom), 0, 0);
    drive_cycle("kill", 0, '0, '0, 1, 1);
    check("kill.occ", 128'(occ_o), 128'(0));
    check("kill.pl",  128'(out_payload()), 128'(0));
    for (int i = 0; i < 3; i++) begin
      drive_cycle("postkill", 0, '0, '0, 1, 0);
      check("postkill.pc", 128'(c_pc_o), 128'(0));
    end

    // kill drops a simultaneous input
    drive_cycle("killin", 1, 32'h300, 20'hABCDE, 0, 1);
    check("killin.valid", 128'(c_valid_o), 128'(0));
    check("killin.addr",  128'(c_addr_o), 128'(0));

    // random traffic
    for (int i = 0; i < 600; i++)
      drive_cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, ADDR_W'($urandom),
                  1'($urandom_range(0, 2) != 0), $urandom_range(0, 40) == 0);

    // asynchronous reset while FULL
    drive_cycle("rfill1", 1, 32'h400, ADDR_W'($urandom), 0, 0);
    drive_cycle("rfill2", 1, 32'h404, ADDR_W'($urandom), 0, 0);
    check("rfill.occ", 128'(occ_o), 128'(2));
    #3;
    rsn_i = 1'b0;
    #1;
    check("areset.valid", 128'(c_valid_o), 128'(0));
    check("areset.ready", 128'(tl_ready_o), 128'(1));
    check("areset.occ",   128'(occ_o), 128'(0));
    check("areset.pc",    128'(c_pc_o), 128'(0));
    exp_q.delete();
    shown_when_empty = '0;
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    drive_cycle("after_reset", 1, 32'h500, ADDR_W'($urandom), 1, 0);
    check("after_reset.pc", 128'(c_pc_o), 128'(32'h500));

`ifdef TL_LATCH_STATS_EN
    rsn_i = 1'b0;
    #1;
    exp_q.delete();
    shown_when_empty = '0;
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    drive_cycle("stats.in", 1, 32'h600, ADDR_W'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) drive_cycle("stats.hold", 0, '0, '0, 0, 0);
    check("stats.stall", 128'(stall_cnt_o), 128'(3));
    drive_cycle("stats.kill", 0, '0, '0, 0, 1);
    drive_cycle("stats.idle", 0, '0, '0, 0, 0);
    check("stats.stall_kill", 128'(stall_cnt_o), 128'(3));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
